// File: rtl/magic_nor_seq.sv
// magic_nor_seq: replays a NOR2/INV program as MAGIC init/evaluate pairs on a one-row cell model.
// Optional cycle counter is built when MAGIC_SEQ_CYCCNT_EN is defined; otherwise cyc_cnt is tied to 0.
module magic_nor_seq #(
   parameter int NCELL = 256,
   parameter int NINST = 256,
   parameter int IN_W  = 10,
   localparam int CW   = $clog2(NCELL),
   localparam int PW   = $clog2(NINST),
   localparam int IW   = 1 + 3*CW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            prog_we,
   input  logic [PW-1:0]   prog_addr,
   input  logic [IW-1:0]   prog_data,
   input  logic [PW:0]     prog_len,
   input  logic [CW-1:0]   out_addr,
   input  logic            start,
   input  logic [IN_W-1:0] in_vec,
   output logic            ready,
   output logic            done,
   output logic            z,
   output logic [15:0]     cyc_cnt
);

   typedef enum logic [2:0] {IDLE, LOAD, INIT, EVAL, FIN} state_t;

   localparam logic [CW:0] NCELL_L = (CW+1)'(NCELL);
   localparam logic [PW:0] NINST_L = (PW+1)'(NINST);

   logic [IW-1:0]    prog_mem [NINST];
   logic [IW-1:0]    inst_reg;
   state_t           state_reg;
   logic [PW:0]      pc_reg, len_reg, pc_inc;
   logic [CW-1:0]    oaddr_reg;
   logic [IN_W-1:0]  vec_reg;
   logic             ready_reg, done_reg, z_reg;
   logic [NCELL-1:0] cell_reg, cell_next, load_val;

   logic             op;
   logic [CW-1:0]    ia, ib, io;
   logic             a_val, b_val, eval_val, z_val;
   logic             rd_en;
   logic [PW-1:0]    rd_addr;

   function automatic logic in_range(input logic [CW-1:0] idx);
      return {1'b0, idx} < NCELL_L;
   endfunction

   assign {op, ia, ib, io} = inst_reg;

   // Operands read the row after INIT, so an output aliasing an operand sees the initialised 1.
   assign a_val    = in_range(ia) ? cell_reg[ia] : 1'b0;
   assign b_val    = in_range(ib) ? cell_reg[ib] : 1'b0;
   assign eval_val = op ? ~a_val : ~(a_val | b_val);
   assign z_val    = in_range(oaddr_reg) ? cell_reg[oaddr_reg] : 1'b0;
   assign pc_inc   = pc_reg + (PW+1)'(1);

   // Instruction for the next INIT/EVAL pair is fetched one cycle ahead (LOAD or EVAL).
   assign rd_en   = (state_reg == LOAD) || (state_reg == EVAL);
   assign rd_addr = (state_reg == EVAL) ? pc_inc[PW-1:0] : '0;

   always_ff @(posedge clk) begin
      if (prog_we && ready_reg && ({1'b0, prog_addr} < NINST_L))
         prog_mem[prog_addr] <= prog_data;
      if (rd_en)
         inst_reg <= prog_mem[rd_addr];
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCELL; gi++) begin : g_load
         if (gi < IN_W) begin : g_in
            assign load_val[gi] = vec_reg[gi];
         end else begin : g_keep
            assign load_val[gi] = cell_reg[gi];
         end
      end
   endgenerate

   always_comb begin
      cell_next = cell_reg;
      case (state_reg)
         LOAD:    cell_next = load_val;
         INIT:    if (in_range(io)) cell_next[io] = 1'b1;
         EVAL:    if (in_range(io)) cell_next[io] = eval_val;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cell_reg <= '0;
      else        cell_reg <= cell_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         len_reg   <= '0;
         oaddr_reg <= '0;
         vec_reg   <= '0;
         ready_reg <= 1'b1;
         done_reg  <= 1'b0;
         z_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  len_reg   <= (prog_len > NINST_L) ? NINST_L : prog_len;
                  oaddr_reg <= out_addr;
                  vec_reg   <= in_vec;
                  pc_reg    <= '0;
                  ready_reg <= 1'b0;
                  state_reg <= LOAD;
               end
            end
            LOAD: state_reg <= (len_reg != '0) ? INIT : FIN;
            INIT: state_reg <= EVAL;
            EVAL: begin
               pc_reg    <= pc_inc;
               state_reg <= (pc_inc < len_reg) ? INIT : FIN;
            end
            FIN: begin
               z_reg     <= z_val;
               done_reg  <= 1'b1;
               ready_reg <= 1'b1;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign ready = ready_reg;
   assign done  = done_reg;
   assign z     = z_reg;

`ifdef MAGIC_SEQ_CYCCNT_EN
   logic [15:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (state_reg == IDLE) begin
         if (start) cnt_reg <= '0;
      end else if (cnt_reg != 16'hFFFF) begin
         cnt_reg <= cnt_reg + 16'd1;
      end
   end

   assign cyc_cnt = cnt_reg;
`else
   assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_magic_nor_seq.sv
// tb_magic_nor_seq: random and directed runs of magic_nor_seq checked against a gate-level row model.
module tb_magic_nor_seq;
   localparam int NC = 256;
   localparam int NI = 256;
   localparam int NW = 10;

   logic        clk = 1'b0, rst_n = 1'b0, prog_we = 1'b0, start = 1'b0;
   logic [7:0]  prog_addr = '0;
   logic [24:0] prog_data = '0;
   logic [8:0]  prog_len = '0;
   logic [7:0]  out_addr = '0;
   logic [9:0]  in_vec = '0;
   logic        ready, done, z;
   logic [15:0] cyc_cnt;

   int n_chk = 0, n_err = 0;
   bit          mcell [NC];
   logic [24:0] mprog [NI];
   logic [24:0] p3 [3];

   magic_nor_seq #(.NCELL(NC), .NINST(NI), .IN_W(NW)) dut (
      .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_len(prog_len), .out_addr(out_addr),
      .start(start), .in_vec(in_vec), .ready(ready), .done(done), .z(z),
      .cyc_cnt(cyc_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [24:0] mk(input int op, input int a, input int b, input int o);
      return {op[0], a[7:0], b[7:0], o[7:0]};
   endfunction

   function automatic logic [24:0] rnd_inst();
      return mk($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
   endfunction

   task automatic write_prog(input int addr, input logic [24:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = addr[7:0]; prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
      mprog[addr] = d;
   endtask

   // Reference: each gate sets its output to 1, then evaluates from the updated row.
   task automatic model_run(input int len, input int oa, input logic [9:0] vec, output bit zo);
      int n, a, b, o;
      bit op, av, bv;
      n = (len > NI) ? NI : len;
      for (int i = 0; i < NW; i++) mcell[i] = vec[i];
      for (int p = 0; p < n; p++) begin
         op = mprog[p][24]; a = mprog[p][23:16]; b = mprog[p][15:8]; o = mprog[p][7:0];
         mcell[o] = 1'b1;
         av = mcell[a]; bv = mcell[b];
         mcell[o] = op ? !av : !(av || bv);
      end
      zo = mcell[oa];
   endtask

   task automatic run(input int len, input int oa, input logic [9:0] vec, input bit disturb);
      bit exp_z, zval, rdy;
      int exp_cyc, exp_cc, cyc, ndone, lim;
      logic [15:0] cc;
      model_run(len, oa, vec, exp_z);
      exp_cyc = 2 * ((len > NI) ? NI : len) + 2;
`ifdef MAGIC_SEQ_CYCCNT_EN
      exp_cc = exp_cyc;
`else
      exp_cc = 0;
`endif
      cyc = 0; ndone = 0; zval = 1'b0; rdy = 1'b0; cc = '0;
      lim = exp_cyc + 12;
      @(negedge clk);
      prog_len = len[8:0]; out_addr = oa[7:0]; in_vec = vec; start = 1'b1;
      for (int k = 1; k <= lim; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            chk("ready_busy", ready, 1'b0);
         end
         if (disturb) begin
            if (k >= 2 && k <= 4) begin
               start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = 25'($urandom);
            end else begin
               start = 1'b0; prog_we = 1'b0;
            end
         end
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               cyc = k - 1; zval = z; rdy = ready; cc = cyc_cnt;
            end
         end
      end
      chk("latency", cyc, exp_cyc);
      chk("done_count", ndone, 1);
      chk("z", zval, exp_z);
      chk("ready_at_done", rdy, 1'b1);
      chk("cyc_cnt", cc, exp_cc);
      chk("z_hold", z, exp_z);
      $display("run len=%0d out=%0d vec=%h z=%0d exp=%0d cycles=%0d", len, oa, vec, zval, exp_z, cyc);
   endtask

   task automatic reset_mid_run();
      for (int i = 0; i < 3; i++) begin
         p3[i] = rnd_inst();
         write_prog(i, p3[i]);
      end
      @(negedge clk);
      prog_len = 9'd3; out_addr = 8'd20; in_vec = 10'h3FF; start = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("rst_ready", ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_z", z, 1'b0);
      chk("rst_cyc_cnt", cyc_cnt, 16'd0);
      @(negedge clk);
      chk("rst_done_held", done, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < NC; i++) mcell[i] = 1'b0;
      $display("reset mid-run applied");
   endtask

   initial begin
      bit dummy;
      for (int i = 0; i < NC; i++) mcell[i] = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_ready", ready, 1'b1);
      chk("reset_done", done, 1'b0);
      chk("reset_z", z, 1'b0);
      chk("reset_cyc_cnt", cyc_cnt, 16'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NI; i++) write_prog(i, rnd_inst());

      // single INV
      write_prog(0, mk(1, 0, 0, 10));
      run(1, 10, 10'h001, 1'b0);
      run(1, 10, 10'h000, 1'b0);
      // NOR2 followed by INV gives OR
      write_prog(0, mk(0, 0, 1, 10));
      write_prog(1, mk(1, 10, 0, 11));
      run(2, 11, 10'h002, 1'b0);
      run(2, 11, 10'h000, 1'b0);
      // zero-length run
      run(0, 3, 10'h008, 1'b0);
      // aliased output
      write_prog(0, mk(0, 0, 1, 0));
      run(1, 0, 10'h000, 1'b0);

      for (int t = 0; t < 30; t++) begin
         if (t % 5 == 0)
            for (int i = 0; i < 4; i++) write_prog($urandom_range(0, 15), rnd_inst());
         run($urandom_range(0, 12), $urandom_range(0, 31), 10'($urandom), 1'b0);
      end

      // length clamp
      run(300, $urandom_range(0, 31), 10'($urandom), 1'b0);

      // busy protection, then rerun with the same program
      for (int i = 0; i < 3; i++) write_prog(i, rnd_inst());
      run(3, 12, 10'($urandom), 1'b1);
      run(3, 12, 10'($urandom), 1'b0);
      write_prog(0, mk(1, 1, 0, 13));
      run(1, 13, 10'h000, 1'b1);
      run(1, 13, 10'h002, 1'b0);

      // reset mid-run, cleared cells, then same program again
      reset_mid_run();
      for (int oa = 10; oa < 32; oa++) run(0, oa, 10'($urandom), 1'b0);
      run(3, 20, 10'h3FF, 1'b0);
      run(3, $urandom_range(0, 31), 10'($urandom), 1'b0);
      model_run(0, 0, 10'h000, dummy);
      run(0, 0, 10'h000, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
